// File: rtl/serial_sum_collector.sv
// serial_sum_collector
//   Collects the registered sum/carry bits of a bit-serial adder, LSB first,
//   into a WIDTH-bit word plus final carry, and offers the word downstream on a
//   valid/ready handshake. The word is held until it is consumed.
//   Framing violations and bits dropped under backpressure raise one-cycle
//   error pulses.
//
// Ports
//   clk_i        rising-edge clock, shared with the adder stage
//   rst_i        asynchronous active-high reset
//   sum_i        serial sum bit
//   cout_i       carry bit, qualified with sum_i
//   bit_valid_i  sum_i/cout_i valid this cycle
//   bit_first_i  marks bit 0 of a word
//   res_ready_i  downstream accepts the result
//   in_ready_o   a bit is accepted this cycle (combinational)
//   res_valid_o  res_data_o/res_carry_o hold a complete word
//   res_data_o   assembled word, bit i = i-th accepted bit
//   res_carry_o  carry captured with the MSB
//   frame_err_o  one-cycle framing-error pulse
//   ovf_err_o    one-cycle pulse when a valid bit is dropped
module serial_sum_collector #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sum_i,
    input  logic             cout_i,
    input  logic             bit_valid_i,
    input  logic             bit_first_i,
    input  logic             res_ready_i,
    output logic             in_ready_o,
    output logic             res_valid_o,
    output logic [WIDTH-1:0] res_data_o,
    output logic             res_carry_o,
    output logic             frame_err_o,
    output logic             ovf_err_o
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StHold
    } state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_carry_q, res_carry_d;
    logic             res_valid_q, res_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             ovf_err_q, ovf_err_d;

    logic             accept;
    logic [WIDTH-1:0] shifted;

    assign in_ready_o = (state_q != StHold) | res_ready_i;
    assign accept     = bit_valid_i & in_ready_o;
    assign shifted    = {sum_i, shreg_q[WIDTH-1:1]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        res_data_d  = res_data_q;
        res_carry_d = res_carry_q;
        res_valid_d = res_valid_q;
        frame_err_d = 1'b0;
        ovf_err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (bit_first_i) begin
                        shreg_d = shifted;
                        cnt_d   = CntOne;
                        state_d = StCollect;
                    end else begin
                        // Stray bit with no word open: drop it, leave shreg/cnt alone.
                        frame_err_d = 1'b1;
                    end
                end
            end

            StCollect: begin
                if (accept) begin
                    shreg_d = shifted;
                    if (bit_first_i) begin
                        // Restart: stale upper bits shift out before the word completes.
                        frame_err_d = 1'b1;
                        cnt_d       = CntOne;
                    end else if (cnt_q == CntMax) begin
                        res_data_d  = shifted;
                        res_carry_d = cout_i;
                        res_valid_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = StHold;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
            end

            StHold: begin
                if (res_ready_i) begin
                    // Word consumed; a completion cannot coincide for WIDTH >= 2.
                    res_valid_d = 1'b0;
                    if (accept && bit_first_i) begin
                        shreg_d = shifted;
                        cnt_d   = CntOne;
                        state_d = StCollect;
                    end else if (accept) begin
                        frame_err_d = 1'b1;
                        state_d     = StIdle;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (bit_valid_i) begin
                    ovf_err_d = 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            shreg_q     <= '0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
            res_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            ovf_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            res_data_q  <= res_data_d;
            res_carry_q <= res_carry_d;
            res_valid_q <= res_valid_d;
            frame_err_q <= frame_err_d;
            ovf_err_q   <= ovf_err_d;
        end
    end

    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign res_carry_o = res_carry_q;
    assign frame_err_o = frame_err_q;
    assign ovf_err_o   = ovf_err_q;

endmodule

// File: tb/tb_serial_sum_collector.sv
// Testbench for serial_sum_collector (WIDTH = 8). Expected words go into a
// scoreboard queue when their bits are driven and are popped when the DUT
// hands a word over (res_valid & res_ready).
module tb_serial_sum_collector;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         sum;
    logic         cout;
    logic         bit_valid;
    logic         bit_first;
    logic         res_ready;
    logic         in_ready;
    logic         res_valid;
    logic [W-1:0] res_data;
    logic         res_carry;
    logic         frame_err;
    logic         ovf_err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int frame_cnt = 0;
    int ovf_cnt = 0;

    logic [W:0] sb_q[$];
    int         xfer_q[$];

    serial_sum_collector #(.WIDTH(W)) u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .sum_i       (sum),
        .cout_i      (cout),
        .bit_valid_i (bit_valid),
        .bit_first_i (bit_first),
        .res_ready_i (res_ready),
        .in_ready_o  (in_ready),
        .res_valid_o (res_valid),
        .res_data_o  (res_data),
        .res_carry_o (res_carry),
        .frame_err_o (frame_err),
        .ovf_err_o   (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) frame_cnt++;
            if (ovf_err) ovf_cnt++;
            if (frame_err || ovf_err) check("err_exclusive", 64'(frame_err & ovf_err), 64'd0);
            if (res_valid && res_ready) begin
                check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    logic [W:0] e;
                    e = sb_q.pop_front();
                    check("res_data", 64'(res_data), 64'(e[W-1:0]));
                    check("res_carry", 64'(res_carry), 64'(e[W]));
                end
                xfer_q.push_back(cyc);
            end
        end
    end

    task automatic drive(input logic s, input logic c, input logic v, input logic f);
        sum       = s;
        cout      = c;
        bit_valid = v;
        bit_first = f;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_word(input logic [W-1:0] d, input logic c);
        sb_q.push_back({c, d});
        for (int i = 0; i < int'(W); i++) begin
            drive(d[i], (i == int'(W) - 1) ? c : 1'b0, 1'b1, (i == 0));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_res_valid"}, 64'(res_valid), 64'd0);
        check({tag, "_res_data"}, 64'(res_data), 64'd0);
        check({tag, "_res_carry"}, 64'(res_carry), 64'd0);
        check({tag, "_frame_err"}, 64'(frame_err), 64'd0);
        check({tag, "_ovf_err"}, 64'(ovf_err), 64'd0);
    endtask

    initial begin
        int f0;
        int o0;
        int x0;
        logic [W-1:0] part;

        rst       = 1'b1;
        sum       = 1'b0;
        cout      = 1'b0;
        bit_valid = 1'b0;
        bit_first = 1'b0;
        res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst = 1'b0;
        idle(1);

        // Single word with carry.
        f0 = frame_cnt;
        o0 = ovf_cnt;
        send_word(8'hA5, 1'b1);
        check("a5_valid_after_last", 64'(res_valid), 64'd1);
        check("a5_data_direct", 64'(res_data), 64'hA5);
        idle(1);
        check("a5_valid_one_cycle", 64'(res_valid), 64'd0);
        check("a5_frame_none", 64'(frame_cnt - f0), 64'd0);
        check("a5_ovf_none", 64'(ovf_cnt - o0), 64'd0);

        // Back-to-back words, no bubble.
        x0 = xfer_q.size();
        send_word(8'h3C, 1'b0);
        check("b2b_valid_first", 64'(res_valid), 64'd1);
        send_word(8'hFF, 1'b1);
        idle(1);
        check("b2b_xfers", 64'(xfer_q.size() - x0), 64'd2);
        if (xfer_q.size() - x0 == 2)
            check("b2b_spacing", 64'(xfer_q[x0+1] - xfer_q[x0]), 64'd8);

        // Backpressure: bits arriving in HOLD are dropped with ovf_err.
        f0 = frame_cnt;
        o0 = ovf_cnt;
        res_ready = 1'b0;
        send_word(8'h5A, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready_low", 64'(in_ready), 64'd0);
            drive(1'b1, 1'b1, (i % 2 == 0), 1'b0);
            check("bp_valid_held", 64'(res_valid), 64'd1);
            check("bp_data_held", 64'(res_data), 64'h5A);
        end
        res_ready = 1'b1;
        send_word(8'h96, 1'b1);
        idle(1);
        check("bp_ovf_count", 64'(ovf_cnt - o0), 64'd3);
        check("bp_frame_none", 64'(frame_cnt - f0), 64'd0);

        // Restart mid-word.
        f0 = frame_cnt;
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        send_word(8'h81, 1'b0);
        idle(1);
        check("restart_frame", 64'(frame_cnt - f0), 64'd1);

        // Stray bit in IDLE.
        idle(2);
        f0 = frame_cnt;
        o0 = ovf_cnt;
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        idle(1);
        check("stray_frame", 64'(frame_cnt - f0), 64'd1);
        send_word(8'h11, 1'b0);
        idle(1);
        check("stray_frame_total", 64'(frame_cnt - f0), 64'd1);
        check("stray_ovf_none", 64'(ovf_cnt - o0), 64'd0);

        // Reset mid-word and in HOLD.
        f0 = frame_cnt;
        o0 = ovf_cnt;
        part = 8'hE7;
        for (int i = 0; i < 6; i++) drive(part[i], 1'b0, 1'b1, (i == 0));
        bit_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        @(posedge clk);
        #1;
        rst = 1'b0;
        res_ready = 1'b0;
        send_word(8'h77, 1'b1);
        check("hold_valid_pre_rst", 64'(res_valid), 64'd1);
        idle(1);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_hold");
        void'(sb_q.pop_back());
        @(posedge clk);
        #1;
        rst = 1'b0;
        res_ready = 1'b1;
        send_word(8'hC3, 1'b1);
        idle(2);
        check("rst_frame_none", 64'(frame_cnt - f0), 64'd0);
        check("rst_ovf_none", 64'(ovf_cnt - o0), 64'd0);

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        check("total_xfers", 64'(xfer_q.size()), 64'd8);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
